// File: rtl/rect_pkg.sv
// Shared constants and FSM encoding for the rectangle-draw scheduler.
package rect_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int RGB_W    = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GO   = 3'd2,
        S_WAIT = 3'd3,
        S_ACK  = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer, wrapping.
module rr_arbiter
    import rect_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [2:0]      ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [2:0]      idx_o,
    output logic            any_o
);

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [3:0]      NREQ_4   = 4'(NREQ);

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic [2:0]        off_s;
    logic [3:0]        sum_s;
    logic [2:0]        idx_s;
    logic              any_s;

    // Rotate requests so the pointer lands on bit 0, then take the lowest set bit.
    always_comb begin
        dbl_s = {req_i, req_i} >> ptr_i;
        rot_s = dbl_s[NREQ-1:0];
        any_s = 1'b0;
        off_s = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            any_s = any_s | rot_s[k];
            off_s = rot_s[k] ? 3'(k) : off_s;
        end
        sum_s = {1'b0, ptr_i} + {1'b0, off_s};
        idx_s = (sum_s >= NREQ_4) ? 3'(sum_s - NREQ_4) : sum_s[2:0];
    end

    assign any_o   = any_s;
    assign idx_o   = idx_s;
    assign grant_o = any_s ? (ONE_HOT0 << idx_s) : {NREQ{1'b0}};

endmodule

// File: rtl/rect_draw_scheduler.sv
// Shares one rectangle engine among NREQ requesters: round-robin grant, frame
// clipping, null-job bypass, go/done handshake and a one-cycle ack to the winner.
module rect_draw_scheduler
    import rect_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SCREEN_W = rect_pkg::SCREEN_W,
    parameter int SCREEN_H = rect_pkg::SCREEN_H
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*X_W-1:0]    req_x0,
    input  logic [NREQ*Y_W-1:0]    req_y0,
    input  logic [NREQ*X_W-1:0]    req_w,
    input  logic [NREQ*Y_W-1:0]    req_h,
    input  logic [NREQ*RGB_W-1:0]  req_rgb,
    output logic [NREQ-1:0]        ack,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [X_W-1:0]         eng_x0,
    output logic [Y_W-1:0]         eng_y0,
    output logic [X_W-1:0]         eng_w,
    output logic [Y_W-1:0]         eng_h,
    output logic [RGB_W-1:0]       eng_rgb,
    output logic                   eng_go,
    input  logic                   eng_done
);

    localparam logic [X_W:0]      SCR_W_EXT = SCREEN_W[X_W:0];
    localparam logic [Y_W:0]      SCR_H_EXT = SCREEN_H[Y_W:0];
    localparam logic [2:0]        LAST_IDX  = 3'(NREQ - 1);
    localparam logic [NREQ-1:0]   ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [2:0]          rr_q, rr_d;
    logic [2:0]          grant_q, grant_d;
    logic [X_W-1:0]      x0_q, x0_d, w_q, w_d;
    logic [Y_W-1:0]      y0_q, y0_d, h_q, h_d;
    logic [RGB_W-1:0]    rgb_q, rgb_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                go_q, go_d;
    logic                busy_q, busy_d;

    logic [NREQ-1:0]     arb_grant_s;
    logic [2:0]          arb_idx_s;
    logic                arb_any_s;

    logic [X_W-1:0]      sel_x0_s, sel_w_s, clip_w_s;
    logic [Y_W-1:0]      sel_y0_s, sel_h_s, clip_h_s;
    logic [RGB_W-1:0]    sel_rgb_s;
    logic [X_W:0]        avail_w_s;
    logic [Y_W:0]        avail_h_s;
    logic                null_s;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (req),
        .ptr_i   (rr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s),
        .any_o   (arb_any_s)
    );

    // Select the winner's fields, clip to the frame and flag jobs with nothing to draw.
    always_comb begin
        sel_x0_s  = {X_W{1'b0}};
        sel_y0_s  = {Y_W{1'b0}};
        sel_w_s   = {X_W{1'b0}};
        sel_h_s   = {Y_W{1'b0}};
        sel_rgb_s = {RGB_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            sel_x0_s  |= req_x0[k*X_W +: X_W]      & {X_W{arb_grant_s[k]}};
            sel_y0_s  |= req_y0[k*Y_W +: Y_W]      & {Y_W{arb_grant_s[k]}};
            sel_w_s   |= req_w[k*X_W +: X_W]       & {X_W{arb_grant_s[k]}};
            sel_h_s   |= req_h[k*Y_W +: Y_W]       & {Y_W{arb_grant_s[k]}};
            sel_rgb_s |= req_rgb[k*RGB_W +: RGB_W] & {RGB_W{arb_grant_s[k]}};
        end
        // Widened by one bit so an off-screen origin cannot wrap into a valid width.
        avail_w_s = SCR_W_EXT - {1'b0, sel_x0_s};
        avail_h_s = SCR_H_EXT - {1'b0, sel_y0_s};
        clip_w_s  = ({1'b0, sel_w_s} > avail_w_s) ? avail_w_s[X_W-1:0] : sel_w_s;
        clip_h_s  = ({1'b0, sel_h_s} > avail_h_s) ? avail_h_s[Y_W-1:0] : sel_h_s;
        null_s    = ({1'b0, sel_x0_s} >= SCR_W_EXT) || ({1'b0, sel_y0_s} >= SCR_H_EXT) ||
                    (sel_w_s == {X_W{1'b0}}) || (sel_h_s == {Y_W{1'b0}});
    end

    // Next-state and registered-output logic for the engine handshake.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        rgb_d   = rgb_q;
        ack_d   = {NREQ{1'b0}};
        go_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_any_s) begin
                    grant_d = arb_idx_s;
                    x0_d    = sel_x0_s;
                    y0_d    = sel_y0_s;
                    w_d     = clip_w_s;
                    h_d     = clip_h_s;
                    rgb_d   = sel_rgb_s;
                    if (null_s) begin
                        state_d = S_ACK;
                        ack_d   = arb_grant_s;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d = S_GO;
                go_d    = 1'b1;
            end
            S_GO: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    state_d = S_ACK;
                    ack_d   = ONE_HOT0 << grant_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                rr_d    = (grant_q == LAST_IDX) ? 3'd0 : grant_q + 3'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any job in flight without an ack.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rr_q    <= 3'd0;
            grant_q <= 3'd0;
            x0_q    <= {X_W{1'b0}};
            y0_q    <= {Y_W{1'b0}};
            w_q     <= {X_W{1'b0}};
            h_q     <= {Y_W{1'b0}};
            rgb_q   <= {RGB_W{1'b0}};
            ack_q   <= {NREQ{1'b0}};
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            rgb_q   <= rgb_d;
            ack_q   <= ack_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign eng_x0   = x0_q;
    assign eng_y0   = y0_q;
    assign eng_w    = w_q;
    assign eng_h    = h_q;
    assign eng_rgb  = rgb_q;
    assign eng_go   = go_q;

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Directed bench for rect_draw_scheduler with a delay-programmable engine model.
module tb_rect_draw_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [31:0] req_x0, req_w;
    logic [27:0] req_y0, req_h;
    logic [11:0] req_rgb;
    logic [3:0]  ack;
    logic        busy, eng_go, eng_done;
    logic [2:0]  grant_id;
    logic [7:0]  eng_x0, eng_w;
    logic [6:0]  eng_y0, eng_h;
    logic [2:0]  eng_rgb;

    logic        model_done, spur_done;
    int          eng_delay = 20;
    int          eng_cnt;
    int          go_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    int          idx, lat, go0;

    rect_draw_scheduler #(.NREQ(4)) dut (
        .clk(clk), .resetn(resetn), .req(req),
        .req_x0(req_x0), .req_y0(req_y0), .req_w(req_w), .req_h(req_h), .req_rgb(req_rgb),
        .ack(ack), .busy(busy), .grant_id(grant_id),
        .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_w(eng_w), .eng_h(eng_h), .eng_rgb(eng_rgb),
        .eng_go(eng_go), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    assign eng_done = model_done | spur_done;

    // Engine: done pulses eng_delay cycles after go is seen.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            eng_cnt    <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (eng_go) begin
                eng_cnt <= eng_delay;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) model_done <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (resetn && eng_go) go_cnt <= go_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_job(input int i, input int x0, input int y0, input int w,
                           input int h, input int rgb);
        req_x0[8*i +: 8]  = 8'(x0);
        req_y0[7*i +: 7]  = 7'(y0);
        req_w[8*i +: 8]   = 8'(w);
        req_h[7*i +: 7]   = 7'(h);
        req_rgb[3*i +: 3] = 3'(rgb);
    endtask

    // Waits for any ack, drops the acknowledged request, reports index and latency.
    task automatic wait_ack(input int budget, output int id, output int n_out);
        id    = -1;
        n_out = 0;
        for (int n = 1; n <= budget && id < 0; n++) begin
            @(negedge clk);
            if (ack != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (ack[i]) id = i;
                n_out = n;
                req   = req & ~ack;
            end
        end
        if (id < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout observed=none expected=ack within %0d cycles", budget);
        end
    endtask

    task automatic chk_eng(input string tag, input int x0, input int y0, input int w,
                           input int h, input int rgb);
        chk({tag, "_x0"}, 64'(eng_x0), 64'(x0));
        chk({tag, "_y0"}, 64'(eng_y0), 64'(y0));
        chk({tag, "_w"},  64'(eng_w),  64'(w));
        chk({tag, "_h"},  64'(eng_h),  64'(h));
        chk({tag, "_rgb"}, 64'(eng_rgb), 64'(rgb));
    endtask

    initial begin
        resetn = 1'b0; req = 4'b0000; spur_done = 1'b0;
        req_x0 = 32'd0; req_w = 32'd0; req_y0 = 28'd0; req_h = 28'd0; req_rgb = 12'd0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({ack, eng_go, busy, grant_id, eng_x0, eng_y0, eng_w, eng_h, eng_rgb}), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single job, engine takes 20 cycles
        eng_delay = 20; set_job(0, 10, 20, 5, 3, 4); go0 = go_cnt; req[0] = 1'b1;
        wait_ack(100, idx, lat);
        chk("t1_idx", 64'(idx), 64'd0);
        chk("t1_lat", 64'(lat), 64'd24);
        chk("t1_go_count", 64'(go_cnt - go0), 64'd1);
        chk("t1_grant_id", 64'(grant_id), 64'd0);
        chk("t1_busy_ack", 64'(busy), 64'd1);
        chk_eng("t1", 10, 20, 5, 3, 4);
        @(negedge clk);
        chk("t1_ack_once", 64'(ack), 64'd0);
        chk("t1_busy_after", 64'(busy), 64'd0);

        // Round-robin with all four requesting from pointer 0
        resetn = 1'b0; repeat (2) @(negedge clk); resetn = 1'b1;
        eng_delay = 3;
        for (int i = 0; i < 4; i++) set_job(i, 10 * i, 5 * i, 8, 4, i);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(60, idx, lat);
            chk($sformatf("t2_order%0d", k), 64'(idx), 64'(k));
            chk($sformatf("t2_x0_%0d", k), 64'(eng_x0), 64'(10 * k));
        end
        req[0] = 1'b1;
        wait_ack(60, idx, lat);
        chk("t2_wrap0", 64'(idx), 64'd0);
        req[0] = 1'b1; req[2] = 1'b1;
        wait_ack(60, idx, lat);
        chk("t2_ptr_first", 64'(idx), 64'd2);
        wait_ack(60, idx, lat);
        chk("t2_ptr_second", 64'(idx), 64'd0);

        // Clipping at the frame edges
        set_job(1, 150, 110, 20, 30, 7); req[1] = 1'b1;
        wait_ack(60, idx, lat);
        chk("t3a_idx", 64'(idx), 64'd1);
        chk_eng("t3a", 150, 110, 10, 10, 7);
        set_job(2, 159, 119, 1, 127, 3); req[2] = 1'b1;
        wait_ack(60, idx, lat);
        chk("t3b_idx", 64'(idx), 64'd2);
        chk_eng("t3b", 159, 119, 1, 1, 3);
        set_job(3, 0, 0, 160, 127, 2); req[3] = 1'b1;
        wait_ack(60, idx, lat);
        chk("t3c_idx", 64'(idx), 64'd3);
        chk_eng("t3c", 0, 0, 160, 120, 2);

        // Spurious done in S_IDLE and in S_LOAD
        @(negedge clk);
        spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
        chk("t5_idle_ack", 64'(ack), 64'd0);
        chk("t5_idle_busy", 64'(busy), 64'd0);
        eng_delay = 5; set_job(0, 5, 5, 5, 5, 1); go0 = go_cnt; req[0] = 1'b1;
        @(negedge clk);
        chk("t5_load_busy", 64'(busy), 64'd1);
        spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
        chk("t5_go_pulse", 64'(eng_go), 64'd1);
        chk("t5_no_early_ack", 64'(ack), 64'd0);
        wait_ack(60, idx, lat);
        chk("t5_idx", 64'(idx), 64'd0);
        chk("t5_lat", 64'(lat), 64'd7);
        chk("t5_go_count", 64'(go_cnt - go0), 64'd1);

        // Null jobs: zero width, x0 off-screen, y0 off-screen
        go0 = go_cnt;
        @(negedge clk); set_job(0, 10, 10, 0, 5, 1); req[0] = 1'b1;
        wait_ack(20, idx, lat);
        chk("t4_w0_idx", 64'(idx), 64'd0);
        chk("t4_w0_lat", 64'(lat), 64'd1);
        @(negedge clk); set_job(1, 170, 10, 5, 5, 1); req[1] = 1'b1;
        wait_ack(20, idx, lat);
        chk("t4_x170_idx", 64'(idx), 64'd1);
        chk("t4_x170_lat", 64'(lat), 64'd1);
        @(negedge clk); set_job(2, 0, 120, 1, 1, 1); req[2] = 1'b1;
        wait_ack(20, idx, lat);
        chk("t4_y120_idx", 64'(idx), 64'd2);
        chk("t4_y120_lat", 64'(lat), 64'd1);
        chk("t4_no_go", 64'(go_cnt - go0), 64'd0);

        // Reset during S_WAIT with pointer at 3; requests 1 and 3 pending
        eng_delay = 30; set_job(1, 40, 50, 60, 30, 5); set_job(3, 1, 2, 3, 4, 6);
        @(negedge clk); req[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_wait_busy", 64'(busy), 64'd1);
        chk("t6_wait_grant", 64'(grant_id), 64'd1);
        req[3] = 1'b1;
        resetn = 1'b0; #1;
        chk("t6_async_clear", 64'({ack, eng_go, busy, grant_id, eng_x0, eng_y0, eng_w, eng_h, eng_rgb}), 64'd0);
        eng_delay = 4;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        wait_ack(60, idx, lat);
        chk("t6_first_idx", 64'(idx), 64'd1);
        chk("t6_first_lat", 64'(lat), 64'd8);
        chk_eng("t6a", 40, 50, 60, 30, 5);
        wait_ack(60, idx, lat);
        chk("t6_second_idx", 64'(idx), 64'd3);
        chk_eng("t6b", 1, 2, 3, 4, 6);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
